dcache_miss_ctrl: RTL and testbench

//  Miss-status holding unit directly upstream of the dcache fill port.

---
 rtl/dcache_miss_ctrl_pkg.sv | 39 +++
 rtl/dcache_miss_ctrl_ps_lowest.sv | 26 ++
 rtl/dcache_miss_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_miss_ctrl_pkg.sv
// Shared types for the dcache miss-status holding unit: bus command, block
// data, cache index/tag, per-entry MSHR state and entry record.
// Latency: n/a (types only).  Backpressure: n/a.
package sys_defs;

   localparam int DCACHE_IDX_W  = 5;
   localparam int DCACHE_TAG_W  = 8;
   // Storage width for memory tags; the controller's MEM_TAG_W must not exceed it.
   localparam int MEM_TAG_MAX_W = 8;

   typedef logic [63:0]             DATA;
   typedef logic [DCACHE_IDX_W-1:0] DCACHE_IDX;
   typedef logic [DCACHE_TAG_W-1:0] DCACHE_TAG;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } BUS_COMMAND;

   typedef enum logic [1:0] {
      FREE       = 2'd0,
      WAIT_ISSUE = 2'd1,
      WAIT_RESP  = 2'd2
   } MSHR_STATE;

   typedef struct packed {
      MSHR_STATE                state;
      DCACHE_IDX                idx;
      DCACHE_TAG                tag;
      logic [MEM_TAG_MAX_W-1:0] mem_tag;
   } MSHR_ENTRY;

   // Byte address of a cache block: {tag, idx, 3'b000}, zero-extended to 64 bits.
   function automatic logic [63:0] blk_addr(input DCACHE_TAG t, input DCACHE_IDX i);
      return 64'({t, i, 3'b000});
   endfunction

endpackage

// File: rtl/dcache_miss_ctrl_ps_lowest.sv
// Priority selector: reports the lowest set bit of req and whether any is set.
// Latency: combinational.  Backpressure: none.
// Ports: req (request vector), vld (any request), idx (lowest requesting index).
module ps_lowest #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0]         req,
   output logic                     vld,
   output logic [$clog2(WIDTH)-1:0] idx
);

   localparam int IDX_W = $clog2(WIDTH);

   // Scan from the top down so the lowest requester is written last and wins.
   always_comb begin
      vld = 1'b0;
      idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (req[i]) begin
            vld = 1'b1;
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Miss-status holding unit feeding the dcache fill port: merges/allocates up to
// two misses per cycle, issues one block load per cycle, matches returning tags.
// Latency: ack and fill are combinational; a new entry issues the cycle after allocation.
// Backpressure: miss_ack=0 means the requester retries; memory rejects (response 0) are retried.
// Ports: clock/reset; miss_req/idx/tag -> miss_ack/miss_id, mshr_full;
//        proc2mem_command/addr, mem2proc_response/data/tag; ld_en/idx/tag/data; fill_valid/fill_id.
module dcache_miss_ctrl
   import sys_defs::*;
#(
   parameter int NUM_MSHR  = 4,
   parameter int MEM_TAG_W = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [1:0]                    miss_req,
   input  logic [2*DCACHE_IDX_W-1:0]     miss_idx,
   input  logic [2*DCACHE_TAG_W-1:0]     miss_tag,
   output logic [1:0]                    miss_ack,
   output logic [2*$clog2(NUM_MSHR)-1:0] miss_id,
   output logic                          mshr_full,
   output BUS_COMMAND                    proc2mem_command,
   output logic [63:0]                   proc2mem_addr,
   input  logic [MEM_TAG_W-1:0]          mem2proc_response,
   input  logic [63:0]                   mem2proc_data,
   input  logic [MEM_TAG_W-1:0]          mem2proc_tag,
   output logic                          ld_en,
   output logic [DCACHE_IDX_W-1:0]       ld_idx,
   output logic [DCACHE_TAG_W-1:0]       ld_tag,
   output logic [63:0]                   ld_data,
   output logic                          fill_valid,
   output logic [$clog2(NUM_MSHR)-1:0]   fill_id
);

   localparam int ID_W = $clog2(NUM_MSHR);

   MSHR_ENTRY mshr     [NUM_MSHR];
   MSHR_ENTRY mshr_nxt [NUM_MSHR];

   logic [NUM_MSHR-1:0] free_vec;
   logic [NUM_MSHR-1:0] issue_vec;
   logic [NUM_MSHR-1:0] free1_req;

   logic                issue_vld;
   logic [ID_W-1:0]     issue_id;
   logic                free0_vld, free1_vld;
   logic [ID_W-1:0]     free0_id, free1_id;

   logic                fill_hit;
   logic [ID_W-1:0]     fill_idx;

   DCACHE_IDX           req_idx   [2];
   DCACHE_TAG           req_tag   [2];
   logic [1:0]          match_vld;
   logic [1:0]          match_fill;
   logic [ID_W-1:0]     match_id  [2];

   logic                ack0, ack1, alloc0, alloc1;
   logic [ID_W-1:0]     id0, id1;

   always_comb begin
      for (int i = 0; i < NUM_MSHR; i++) begin
         free_vec[i]  = (mshr[i].state == FREE);
         issue_vec[i] = (mshr[i].state == WAIT_ISSUE);
      end
   end

   ps_lowest #(.WIDTH(NUM_MSHR)) u_issue_pick (.req(issue_vec), .vld(issue_vld), .idx(issue_id));
   ps_lowest #(.WIDTH(NUM_MSHR)) u_free0_pick (.req(free_vec),  .vld(free0_vld), .idx(free0_id));

   // Port 1 may not take the entry port 0 is allocating this cycle.
   assign free1_req = free_vec & ~(alloc0 ? (NUM_MSHR'(1) << free0_id) : '0);

   ps_lowest #(.WIDTH(NUM_MSHR)) u_free1_pick (.req(free1_req), .vld(free1_vld), .idx(free1_id));

   // Fill match. Issuing entries hold mem_tag 0 and tag 0 is never a fill, so they cannot match.
   always_comb begin
      fill_hit = 1'b0;
      fill_idx = '0;
      for (int i = 0; i < NUM_MSHR; i++) begin
         if (mshr[i].state == WAIT_RESP && mem2proc_tag != '0 &&
             mshr[i].mem_tag == MEM_TAG_MAX_W'(mem2proc_tag)) begin
            fill_hit = 1'b1;
            fill_idx = ID_W'(i);
         end
      end
   end

   // Block match of each miss port against outstanding entries.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         req_idx[p]    = miss_idx[p*DCACHE_IDX_W +: DCACHE_IDX_W];
         req_tag[p]    = miss_tag[p*DCACHE_TAG_W +: DCACHE_TAG_W];
         match_vld[p]  = 1'b0;
         match_fill[p] = 1'b0;
         match_id[p]   = '0;
         for (int i = 0; i < NUM_MSHR; i++) begin
            if (mshr[i].state != FREE && mshr[i].idx == req_idx[p] && mshr[i].tag == req_tag[p]) begin
               match_vld[p]  = 1'b1;
               match_id[p]   = ID_W'(i);
               match_fill[p] = fill_hit && (fill_idx == ID_W'(i));
            end
         end
      end
   end

   // Allocate / merge decision. A miss on the block completing this cycle is
   // refused: the fill lands at this edge, so the retry hits in the dcache.
   always_comb begin
      ack0   = 1'b0;
      alloc0 = 1'b0;
      id0    = '0;
      ack1   = 1'b0;
      alloc1 = 1'b0;
      id1    = '0;
      if (!reset && miss_req[0] && !match_fill[0]) begin
         if (match_vld[0]) begin
            ack0 = 1'b1;
            id0  = match_id[0];
         end else if (free0_vld) begin
            ack0   = 1'b1;
            alloc0 = 1'b1;
            id0    = free0_id;
         end
      end
      if (!reset && miss_req[1] && !match_fill[1]) begin
         if (match_vld[1]) begin
            ack1 = 1'b1;
            id1  = match_id[1];
         end else if (alloc0 && req_idx[1] == req_idx[0] && req_tag[1] == req_tag[0]) begin
            ack1 = 1'b1;
            id1  = free0_id;
         end else if (free1_vld) begin
            ack1   = 1'b1;
            alloc1 = 1'b1;
            id1    = free1_id;
         end
      end
   end

   // Entry state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_MSHR; i++) begin
            mshr[i] <= '{state: FREE, idx: '0, tag: '0, mem_tag: '0};
         end
      end else begin
         mshr <= mshr_nxt;
      end
   end

   // Entry next state. Allocation only targets FREE entries, while issue and
   // fill only touch busy ones, so these updates never collide.
   always_comb begin
      mshr_nxt = mshr;
      if (issue_vld && mem2proc_response != '0) begin
         mshr_nxt[issue_id].state   = WAIT_RESP;
         mshr_nxt[issue_id].mem_tag = MEM_TAG_MAX_W'(mem2proc_response);
      end
      if (fill_hit) begin
         mshr_nxt[fill_idx].state   = FREE;
         mshr_nxt[fill_idx].mem_tag = '0;
      end
      if (alloc0) begin
         mshr_nxt[free0_id] = '{state: WAIT_ISSUE, idx: req_idx[0], tag: req_tag[0], mem_tag: '0};
      end
      if (alloc1) begin
         mshr_nxt[free1_id] = '{state: WAIT_ISSUE, idx: req_idx[1], tag: req_tag[1], mem_tag: '0};
      end
   end

   // Outputs.
   always_comb begin
      miss_ack         = {ack1, ack0};
      miss_id          = {id1, id0};
      mshr_full        = ~|free_vec;
      proc2mem_command = issue_vld ? BUS_LOAD : BUS_NONE;
      proc2mem_addr    = issue_vld ? blk_addr(mshr[issue_id].tag, mshr[issue_id].idx) : 64'd0;
      ld_en            = fill_hit;
      ld_idx           = mshr[fill_idx].idx;
      ld_tag           = mshr[fill_idx].tag;
      ld_data          = mem2proc_data;
      fill_valid       = fill_hit;
      fill_id          = fill_idx;
   end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// Ports: drives every DUT port; prints one summary line at the end.
module tb_dcache_miss_ctrl;
   import sys_defs::*;

   logic              clock;
   logic              reset;
   logic [1:0]        miss_req;
   logic [9:0]        miss_idx;
   logic [15:0]       miss_tag;
   logic [1:0]        miss_ack;
   logic [3:0]        miss_id;
   logic              mshr_full;
   BUS_COMMAND        proc2mem_command;
   logic [63:0]       proc2mem_addr;
   logic [3:0]        mem2proc_response;
   logic [63:0]       mem2proc_data;
   logic [3:0]        mem2proc_tag;
   logic              ld_en;
   logic [4:0]        ld_idx;
   logic [7:0]        ld_tag;
   logic [63:0]       ld_data;
   logic              fill_valid;
   logic [1:0]        fill_id;

   int checks;
   int errors;

   dcache_miss_ctrl #(.NUM_MSHR(4), .MEM_TAG_W(4)) dut (
      .clock             (clock),
      .reset             (reset),
      .miss_req          (miss_req),
      .miss_idx          (miss_idx),
      .miss_tag          (miss_tag),
      .miss_ack          (miss_ack),
      .miss_id           (miss_id),
      .mshr_full         (mshr_full),
      .proc2mem_command  (proc2mem_command),
      .proc2mem_addr     (proc2mem_addr),
      .mem2proc_response (mem2proc_response),
      .mem2proc_data     (mem2proc_data),
      .mem2proc_tag      (mem2proc_tag),
      .ld_en             (ld_en),
      .ld_idx            (ld_idx),
      .ld_tag            (ld_tag),
      .ld_data           (ld_data),
      .fill_valid        (fill_valid),
      .fill_id           (fill_id)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle();
      miss_req          = 2'b00;
      miss_idx          = '0;
      miss_tag          = '0;
      mem2proc_response = '0;
      mem2proc_tag      = '0;
      mem2proc_data     = '0;
   endtask

   task automatic drive_miss(input logic [1:0] req, input logic [4:0] i0, input logic [7:0] t0,
                             input logic [4:0] i1, input logic [7:0] t1);
      miss_req = req;
      miss_idx = {i1, i0};
      miss_tag = {t1, t0};
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      idle();
      @(negedge clock);

      // Reset state, with a miss presented while reset is held.
      drive_miss(2'b01, 5'd5, 8'h12, 5'd0, 8'h00);
      #1;
      check("rst_cmd",   64'(proc2mem_command), 64'(BUS_NONE));
      check("rst_ld_en", 64'(ld_en),      64'd0);
      check("rst_fill",  64'(fill_valid), 64'd0);
      check("rst_ack",   64'(miss_ack),   64'd0);
      check("rst_full",  64'(mshr_full),  64'd0);
      step();
      reset = 1'b0;
      idle();

      // 1: single miss, accepted next cycle, data two cycles later.
      drive_miss(2'b01, 5'd5, 8'h12, 5'd0, 8'h00);
      #1;
      check("t1_ack",      64'(miss_ack),         64'd1);
      check("t1_id",       64'(miss_id[1:0]),     64'd0);
      check("t1_no_issue", 64'(proc2mem_command), 64'(BUS_NONE));
      step();
      idle();
      mem2proc_response = 4'd3;
      #1;
      check("t1_cmd",  64'(proc2mem_command), 64'(BUS_LOAD));
      check("t1_addr", proc2mem_addr,         64'h1228);
      step();
      mem2proc_response = 4'd0;
      #1;
      check("t1_one_load", 64'(proc2mem_command), 64'(BUS_NONE));
      step();
      mem2proc_tag  = 4'd3;
      mem2proc_data = 64'hDEAD_0000_0000_0001;
      drive_miss(2'b01, 5'd5, 8'h12, 5'd0, 8'h00);
      #1;
      check("t1_ld_en",   64'(ld_en),      64'd1);
      check("t1_ld_idx",  64'(ld_idx),     64'd5);
      check("t1_ld_tag",  64'(ld_tag),     64'h12);
      check("t1_fill",    64'(fill_valid), 64'd1);
      check("t1_fill_id", 64'(fill_id),    64'd0);
      check("t1_ld_data", ld_data,         64'hDEAD_0000_0000_0001);
      check("t1_ack_completing", 64'(miss_ack), 64'd0);
      step();
      idle();
      #1;
      check("t1_ld_off",  64'(ld_en),            64'd0);
      check("t1_freed",   64'(proc2mem_command), 64'(BUS_NONE));

      // 2: both ports miss on the same block in one cycle.
      do_reset();
      drive_miss(2'b11, 5'd7, 8'h34, 5'd7, 8'h34);
      #1;
      check("t2_ack", 64'(miss_ack), 64'd3);
      check("t2_ids", 64'(miss_id),  64'd0);
      step();
      idle();
      mem2proc_response = 4'd5;
      #1;
      check("t2_cmd",  64'(proc2mem_command), 64'(BUS_LOAD));
      check("t2_addr", proc2mem_addr,         64'h3438);
      step();
      mem2proc_response = 4'd0;
      #1;
      check("t2_one_load", 64'(proc2mem_command), 64'(BUS_NONE));
      step();
      mem2proc_tag = 4'd5;
      #1;
      check("t2_fill",    64'(fill_valid), 64'd1);
      check("t2_fill_id", 64'(fill_id),    64'd0);
      step();

      // 3: memory rejects three times, then accepts with tag 7.
      do_reset();
      drive_miss(2'b01, 5'd1, 8'h01, 5'd0, 8'h00);
      #1;
      check("t3_ack", 64'(miss_ack), 64'd1);
      step();
      idle();
      for (int k = 0; k < 4; k++) begin
         mem2proc_response = (k == 3) ? 4'd7 : 4'd0;
         #1;
         check("t3_cmd",  64'(proc2mem_command), 64'(BUS_LOAD));
         check("t3_addr", proc2mem_addr,         64'h0108);
         step();
      end
      mem2proc_response = 4'd0;
      #1;
      check("t3_no_reissue", 64'(proc2mem_command), 64'(BUS_NONE));
      step();
      mem2proc_tag = 4'd7;
      #1;
      check("t3_fill",    64'(fill_valid), 64'd1);
      check("t3_fill_id", 64'(fill_id),    64'd0);
      step();

      // 4: fill all four entries, fifth miss refused until one completes.
      do_reset();
      drive_miss(2'b11, 5'd1, 8'h40, 5'd2, 8'h40);
      #1;
      check("t4_ackA", 64'(miss_ack), 64'd3);
      check("t4_idsA", 64'(miss_id),  64'b0100);
      step();
      drive_miss(2'b11, 5'd3, 8'h40, 5'd4, 8'h40);
      #1;
      check("t4_ackB",  64'(miss_ack),  64'd3);
      check("t4_idsB",  64'(miss_id),   64'b1110);
      check("t4_notfull", 64'(mshr_full), 64'd0);
      step();
      drive_miss(2'b01, 5'd5, 8'h40, 5'd0, 8'h00);
      mem2proc_response = 4'd9;
      #1;
      check("t4_full",   64'(mshr_full),     64'd1);
      check("t4_nack",   64'(miss_ack),      64'd0);
      check("t4_addr",   proc2mem_addr,      64'h4008);
      step();
      mem2proc_response = 4'd0;
      mem2proc_tag      = 4'd9;
      #1;
      check("t4_nack_fill", 64'(miss_ack),   64'd0);
      check("t4_fill",      64'(fill_valid), 64'd1);
      check("t4_fill_id",   64'(fill_id),    64'd0);
      check("t4_full_fill", 64'(mshr_full),  64'd1);
      step();
      mem2proc_tag = 4'd0;
      #1;
      check("t4_ack5",    64'(miss_ack),     64'd1);
      check("t4_id5",     64'(miss_id[1:0]), 64'd0);
      check("t4_notfull2", 64'(mshr_full),   64'd0);
      step();
      idle();

      // 5: out-of-order responses.
      do_reset();
      drive_miss(2'b11, 5'd10, 8'h20, 5'd11, 8'h21);
      #1;
      check("t5_ids", 64'(miss_id), 64'b0100);
      step();
      idle();
      mem2proc_response = 4'd1;
      #1;
      check("t5_addrA", proc2mem_addr, 64'h2050);
      step();
      mem2proc_response = 4'd2;
      #1;
      check("t5_addrB", proc2mem_addr, 64'h2158);
      step();
      mem2proc_response = 4'd0;
      mem2proc_tag      = 4'd2;
      mem2proc_data     = 64'h2222_3333_4444_5555;
      #1;
      check("t5_fill_id1", 64'(fill_id), 64'd1);
      check("t5_idx1",     64'(ld_idx),  64'd11);
      check("t5_tag1",     64'(ld_tag),  64'h21);
      check("t5_data1",    ld_data,      64'h2222_3333_4444_5555);
      step();
      mem2proc_tag  = 4'd1;
      mem2proc_data = 64'h1111_AAAA_BBBB_CCCC;
      #1;
      check("t5_fill_id0", 64'(fill_id), 64'd0);
      check("t5_idx0",     64'(ld_idx),  64'd10);
      check("t5_data0",    ld_data,      64'h1111_AAAA_BBBB_CCCC);
      step();
      mem2proc_tag = 4'd0;
      #1;
      check("t5_done", 64'(ld_en), 64'd0);
      step();

      // 6: reset with two entries waiting on memory; late tags are ignored.
      do_reset();
      drive_miss(2'b11, 5'd12, 8'h50, 5'd13, 8'h51);
      step();
      idle();
      mem2proc_response = 4'd4;
      step();
      mem2proc_response = 4'd5;
      step();
      mem2proc_response = 4'd0;
      reset = 1'b1;
      step();
      mem2proc_tag = 4'd4;
      #1;
      check("t6_rst_ld", 64'(ld_en), 64'd0);
      reset = 1'b0;
      #1;
      check("t6_late4_ld",   64'(ld_en),      64'd0);
      check("t6_late4_fill", 64'(fill_valid), 64'd0);
      step();
      mem2proc_tag = 4'd5;
      drive_miss(2'b11, 5'd1, 8'h60, 5'd2, 8'h60);
      #1;
      check("t6_late5_ld", 64'(ld_en),            64'd0);
      check("t6_cmd",      64'(proc2mem_command), 64'(BUS_NONE));
      check("t6_ack",      64'(miss_ack),         64'd3);
      check("t6_ids",      64'(miss_id),          64'b0100);
      step();
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
